// File: rtl/result_wb_buffer.sv
// Purpose : collapsing in-order result buffer between the integer ALU and the shared register-file write port.
// Latency : 1 cycle enqueue-to-OUT_uop; 0 cycles when RESULT_WB_BYPASS_EN is defined and the buffer is empty.
// Backpr. : OUT_stall rises at count >= DEPTH-1; IN_wbReady=0 holds the head, which stays valid until consumed or killed.
//
// Optional feature macro: RESULT_WB_BYPASS_EN (empty-buffer same-cycle bypass of IN_uop onto OUT_uop).
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-low reset
//   IN_uop     - result from the ALU output register (valid, result, tagDst, doNotCommit, sqN, flags)
//   IN_branch  - branch/flush broadcast; taken + sqN kill every younger result
//   IN_wbReady - write port accepts OUT_uop this cycle
//   OUT_uop    - oldest surviving result; fields are don't-care while valid=0
//   OUT_stall  - issue backpressure toward the ALU issue queue
//   OUT_count  - number of stored entries

package result_wb_pkg;
    typedef logic [6:0] SqN_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [6:0]  tagDst;
        logic        doNotCommit;
        SqN_t        sqN;
        logic [3:0]  flags;
    } RES_UOp;

    typedef struct packed {
        logic taken;
        SqN_t sqN;
    } BranchProv;
endpackage

module result_wb_buffer
    import result_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  RES_UOp                     IN_uop,
    input  BranchProv                  IN_branch,
    input  logic                       IN_wbReady,
    output RES_UOp                     OUT_uop,
    output logic                       OUT_stall,
    output logic [$clog2(DEPTH+1)-1:0] OUT_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

    RES_UOp         slots    [DEPTH];
    RES_UOp         nxtSlots [DEPTH];
    logic [CW-1:0]  count;
    logic [CW-1:0]  nxtCount;
    logic           ovf;
    logic           setOvf;

    logic           headLive;
    logic           inLive;
    logic           bypassSel;
    logic           bypassTaken;
    logic           pop;
    logic           outValid;

    // x is killed when it is strictly younger than the branch: the sqN
    // difference, read as a signed value of the sqN width, is positive.
    function automatic logic isKilled(input SqN_t s, input BranchProv br);
        SqN_t d;
        d = s - br.sqN;
        return br.taken && !d[$bits(SqN_t)-1] && (d != '0);
    endfunction

    always_comb begin
        int   kept;
        logic keep;

        nxtSlots = '{default: '0};
        setOvf   = 1'b0;
        kept     = 0;
        keep     = 1'b0;

        headLive = slots[0].valid && !isKilled(slots[0].sqN, IN_branch);
        inLive   = IN_uop.valid && !isKilled(IN_uop.sqN, IN_branch);
`ifdef RESULT_WB_BYPASS_EN
        bypassSel = (count == '0) && inLive;
`else
        bypassSel = 1'b0;
`endif
        bypassTaken = bypassSel && IN_wbReady;
        pop         = headLive && IN_wbReady && !bypassSel;

        // Compaction: each survivor moves to the slot equal to the number of
        // survivors ahead of it, so arrival order is kept without a shifter chain.
        for (int i = 0; i < DEPTH; i++) begin
            keep = slots[i].valid && !isKilled(slots[i].sqN, IN_branch) && !(i == 0 && pop);
            if (keep) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == kept) begin
                        nxtSlots[j] = slots[i];
                    end
                end
                kept++;
            end
        end

        // New result lands right behind the survivors. With every slot still
        // occupied after pop/kill there is nowhere to put it: drop and flag.
        if (inLive && !bypassTaken) begin
            if (kept == DEPTH) begin
                setOvf = 1'b1;
            end else begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == kept) begin
                        nxtSlots[j] = IN_uop;
                    end
                end
                kept++;
            end
        end

        nxtCount = CW'(kept);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots <= '{default: '0};
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            slots <= nxtSlots;
            count <= nxtCount;
            ovf   <= ovf | setOvf;
        end
    end

    // rst gating keeps OUT_uop.valid low during reset even when the bypass
    // path would otherwise forward a live IN_uop.
    always_comb begin
        outValid = rst && (bypassSel || headLive);
        if (bypassSel) begin
            OUT_uop = IN_uop;
        end else begin
            OUT_uop = slots[0];
        end
        if (!outValid) begin
            OUT_uop = 'x;
        end
        OUT_uop.valid = outValid;
    end

    assign OUT_stall = (count >= STALL_LVL);
    assign OUT_count = count;

endmodule

// File: tb/tb_result_wb_buffer.sv
// Purpose : randomized + directed scoreboard bench for result_wb_buffer.
// Latency : reference model is an arrival-ordered queue; head is expected when alive.
// Backpr. : stimulus mostly honours OUT_stall, with deliberate overflow sequences.
module tb_result_wb_buffer;
    import result_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    RES_UOp        IN_uop;
    BranchProv     IN_branch;
    logic          IN_wbReady;
    RES_UOp        OUT_uop;
    logic          OUT_stall;
    logic [CW-1:0] OUT_count;

    int     nChecks = 0;
    int     nPass   = 0;
    bit     endReq  = 1'b0;
    RES_UOp expQ[$];

    result_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .IN_uop    (IN_uop),
        .IN_branch (IN_branch),
        .IN_wbReady(IN_wbReady),
        .OUT_uop   (OUT_uop),
        .OUT_stall (OUT_stall),
        .OUT_count (OUT_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit killedBy(input SqN_t s);
        SqN_t d;
        d = s - IN_branch.sqN;
        return IN_branch.taken && ($signed(d) > 7'sd0);
    endfunction

    // Monitor + reference model. Negedge: compare outputs against the oldest
    // surviving expected entry and retire it if the write port takes it.
    // Posedge: drop killed entries and append the issued result if it fits.
    always begin : monitor
        RES_UOp expU;
        bit     expValid;
        bit     fromIn;
        bit     bypassConsumed;

        @(negedge clk);
        expValid = 1'b0;
        fromIn   = 1'b0;
        expU     = '0;
        if (!rst) begin
            expQ.delete();
        end else if (expQ.size() > 0) begin
            if (!killedBy(expQ[0].sqN)) begin
                expValid = 1'b1;
                expU     = expQ[0];
            end
        end
`ifdef RESULT_WB_BYPASS_EN
        else if (IN_uop.valid && !killedBy(IN_uop.sqN)) begin
            expValid = 1'b1;
            expU     = IN_uop;
            fromIn   = 1'b1;
        end
`endif
        check("out_valid", OUT_uop.valid, expValid);
        check("out_count", OUT_count, expQ.size());
        check("out_stall", OUT_stall, expQ.size() >= DEPTH-1);
        if (expValid && OUT_uop.valid) begin
            check("out_sqN",    OUT_uop.sqN,         expU.sqN);
            check("out_result", OUT_uop.result,      expU.result);
            check("out_tagDst", OUT_uop.tagDst,      expU.tagDst);
            check("out_flags",  OUT_uop.flags,       expU.flags);
            check("out_dnc",    OUT_uop.doNotCommit, expU.doNotCommit);
        end
        bypassConsumed = fromIn && IN_wbReady;
        if (expValid && IN_wbReady && !fromIn) void'(expQ.pop_front());
        if (endReq) check("drained", expQ.size(), 0);

        @(posedge clk);
        if (rst) begin
            for (int i = expQ.size()-1; i >= 0; i--) begin
                if (killedBy(expQ[i].sqN)) expQ.delete(i);
            end
            if (IN_uop.valid && !killedBy(IN_uop.sqN) && !bypassConsumed && expQ.size() < DEPTH)
                expQ.push_back(IN_uop);
        end
    end

    task automatic step(input bit v, input SqN_t sq, input bit rdy, input bit bt, input SqN_t bsq);
        IN_uop.valid       = v;
        IN_uop.sqN         = sq;
        IN_uop.result      = $urandom();
        IN_uop.tagDst      = 7'($urandom());
        IN_uop.flags       = 4'($urandom());
        IN_uop.doNotCommit = 1'($urandom());
        IN_branch.taken    = bt;
        IN_branch.sqN      = bsq;
        IN_wbReady         = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && expQ.size() > 0; n++) step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0);
        step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0);
    endtask

    initial begin : stim
        SqN_t nextSq;
        SqN_t bsq;
        bit   v;
        bit   r;
        bit   bt;

        IN_uop     = '0;
        IN_branch  = '0;
        IN_wbReady = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // In-order drain with ready held high.
        step(1'b1, 7'd5, 1'b1, 1'b0, 7'd0);
        step(1'b1, 7'd6, 1'b1, 1'b0, 7'd0);
        step(1'b1, 7'd7, 1'b1, 1'b0, 7'd0);
        drain();

        // Backpressure: three stored, stall up, then ordered release.
        step(1'b1, 7'd1, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd2, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd3, 1'b0, 1'b0, 7'd0);
        step(1'b0, 7'd0, 1'b0, 1'b0, 7'd0);
        drain();

        // Flush compaction: 14 and 15 are younger than 12.
        step(1'b1, 7'd10, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd14, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd11, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd15, 1'b0, 1'b0, 7'd0);
        step(1'b0, 7'd0,  1'b0, 1'b1, 7'd12);
        step(1'b0, 7'd0,  1'b0, 1'b0, 7'd0);
        drain();

        // Pop, kill and enqueue in one edge.
        step(1'b1, 7'd20, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd21, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd22, 1'b1, 1'b1, 7'd21);
        step(1'b0, 7'd0,  1'b0, 1'b0, 7'd0);
        drain();

        // Head kill while ready is high.
        step(1'b1, 7'd9, 1'b0, 1'b0, 7'd0);
        step(1'b0, 7'd0, 1'b1, 1'b1, 7'd8);
        drain();

        // Overflow: fifth result with all slots full is dropped.
        for (int i = 0; i < 5; i++) step(1'b1, 7'(50 + i), 1'b0, 1'b0, 7'd0);
        drain();

        // Asynchronous reset with three entries held.
        step(1'b1, 7'd60, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd61, 1'b0, 1'b0, 7'd0);
        step(1'b1, 7'd62, 1'b0, 1'b0, 7'd0);
        IN_uop.valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 7'd63, 1'b1, 1'b0, 7'd0);
        drain();

        // Randomized traffic.
        nextSq = 7'd40;
        repeat (400) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            bt = ($urandom_range(0, 9) == 0);
            if (OUT_stall && $urandom_range(0, 7) != 0) v = 1'b0;
            bsq = nextSq - 7'($urandom_range(1, 5));
            step(v, nextSq, r, bt, bsq);
            if (v) nextSq = nextSq + 7'd1;
        end
        drain();

        endReq = 1'b1;
        step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0);
        step(1'b0, 7'd0, 1'b1, 1'b0, 7'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
